// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO family.
package fifo_pkg;

    // Read-mode selector; its numeric value can drive the FWFT parameter.
    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Parameter legality: power-of-two depth, thresholds inside the usable range.
    function automatic bit params_ok(input int dw, input int depth,
                                     input int af, input int ae);
        return (dw >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: flop array, synchronous write, combinational read, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    // Storage write; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised synchronous FIFO with registered flags, occupancy count,
// sticky overflow/underflow, synchronous flush and optional FWFT read mode.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0,
    localparam int CW        = fifo_pkg::cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);
    import fifo_pkg::*;

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    if (!params_ok(DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
        $error("sync_fifo_flags: illegal DATA_WIDTH/DEPTH/threshold parameters");
    end

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt_nxt;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd;

    // A full FIFO still takes a write when a pop frees a slot the same cycle;
    // an empty FIFO never bypasses, so a read alongside the first write is rejected.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_en);

    // Next occupancy; flags are registered from this so they line up with count.
    always_comb begin
        cnt_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_nxt = count + CW'(1);
            2'b01:   cnt_nxt = count - CW'(1);
            default: cnt_nxt = count;
        endcase
    end

    // Pointers, count, level flags and sticky errors; flush outranks traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            count        <= cnt_nxt;
            empty        <= (cnt_nxt == '0);
            full         <= (cnt_nxt == FULL_C);
            almost_empty <= (cnt_nxt <= AE_C);
            almost_full  <= (cnt_nxt >= AF_C);
            overflow     <= overflow  | (wr_en & ~wr_acc);
            underflow    <= underflow | (rd_en & ~rd_acc);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~flush),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (mem_rd)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; forced to zero while empty so the
        // output is clean out of reset even though storage is not reset.
        assign data_out = empty ? '0 : mem_rd;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;

        // Standard mode: head word captured on an accepted pop, held otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                 dout_q <= '0;
            else if (!flush && rd_acc) dout_q <= mem_rd;
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: one standard-mode and one FWFT instance share all stimulus.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en;
    logic [7:0] data_in;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [3:0] s_cnt, f_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2),
                      .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ov), .underflow(s_un));

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2),
                      .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ov), .underflow(f_un));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given request; outputs sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic f = 1'b0);
        wr_en = w; rd_en = r; data_in = d; flush = f;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(s_cnt), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_full",  32'(s_full), 32'd0);
        chk("rst_ae",    32'(s_ae), 32'd1);
        chk("rst_af",    32'(s_af), 32'd0);
        chk("rst_ov_un", 32'({s_ov, s_un}), 32'd0);
        chk("rst_dout",  32'(s_dout), 32'd0);
        chk("rst_fw_dout", 32'(f_dout), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FWFT: written word is visible after one edge without a read
        cyc(1, 0, 8'h7E);
        chk("fw_empty_after_wr", 32'(f_empty), 32'd0);
        chk("fw_dout_7e", 32'(f_dout), 32'h7E);
        chk("std_dout_unread", 32'(s_dout), 32'd0);
        cyc(0, 1, 8'h00);
        chk("fw_empty_after_rd", 32'(f_empty), 32'd1);
        chk("std_dout_7e", 32'(s_dout), 32'h7E);

        // Fill: count steps 1..8 with level flags at their thresholds
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 8'(i));
            chk($sformatf("fill_count_%0d", i), 32'(s_cnt), 32'(i));
            chk($sformatf("fill_ae_%0d", i), 32'(s_ae), (i <= 2) ? 32'd1 : 32'd0);
            chk($sformatf("fill_af_%0d", i), 32'(s_af), (i >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("fill_full_%0d", i), 32'(s_full), (i == 8) ? 32'd1 : 32'd0);
        end

        // Overflow: write alone into a full FIFO is rejected
        cyc(1, 0, 8'hAA);
        chk("ovf_flag", 32'(s_ov), 32'd1);
        chk("ovf_count", 32'(s_cnt), 32'd8);
        chk("ovf_no_un", 32'(s_un), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 8'h00);
            chk($sformatf("drain_dout_%0d", i), 32'(s_dout), 32'(i));
        end
        chk("drain_empty", 32'(s_empty), 32'd1);
        chk("drain_count", 32'(s_cnt), 32'd0);

        // Full with simultaneous write and read: both accepted, wrap-around
        for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
        cyc(1, 1, 8'h55);
        chk("wr_rd_full_count", 32'(s_cnt), 32'd8);
        chk("wr_rd_full_full", 32'(s_full), 32'd1);
        chk("wr_rd_full_dout", 32'(s_dout), 32'h01);
        for (int i = 2; i <= 9; i++) begin
            cyc(0, 1, 8'h00);
            chk($sformatf("wrap_dout_%0d", i), 32'(s_dout), (i == 9) ? 32'h55 : 32'(i));
        end
        chk("wrap_empty", 32'(s_empty), 32'd1);

        // Underflow: read of empty FIFO rejected, output held
        cyc(0, 1, 8'h00);
        chk("unf_flag", 32'(s_un), 32'd1);
        chk("unf_dout_held", 32'(s_dout), 32'h55);
        cyc(1, 1, 8'h33);
        chk("empty_wr_rd_count", 32'(s_cnt), 32'd1);
        chk("empty_wr_rd_dout", 32'(s_dout), 32'h55);
        cyc(0, 1, 8'h00);
        chk("empty_wr_rd_data", 32'(s_dout), 32'h33);

        // Flush with count=5 and sticky errors set; write in flush cycle dropped
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h10 + i));
        chk("pre_flush_count", 32'(s_cnt), 32'd5);
        chk("pre_flush_ov", 32'(s_ov), 32'd1);
        cyc(1, 0, 8'h99, 1'b1);
        chk("flush_count", 32'(s_cnt), 32'd0);
        chk("flush_empty", 32'(s_empty), 32'd1);
        chk("flush_ae", 32'(s_ae), 32'd1);
        chk("flush_errs", 32'({s_ov, s_un}), 32'd0);
        chk("flush_dout_held", 32'(s_dout), 32'h33);
        chk("fw_flush_count", 32'(f_cnt), 32'd0);

        // Async reset mid-burst clears state before any clock edge
        cyc(1, 0, 8'h21);
        cyc(1, 1, 8'h22);
        chk("burst_dout", 32'(s_dout), 32'h21);
        chk("burst_count", 32'(s_cnt), 32'd1);
        wr_en = 1'b1; data_in = 8'h23;
        #3 rst = 1'b1;
        #1;
        chk("arst_count", 32'(s_cnt), 32'd0);
        chk("arst_empty", 32'(s_empty), 32'd1);
        chk("arst_dout", 32'(s_dout), 32'd0);
        chk("arst_fw_empty", 32'(f_empty), 32'd1);
        wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_count", 32'(s_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised synchronous FIFO and the next generation of the team's 8×8 FIFO. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, and a selectable first-word-fall-through (FWFT) read mode. It also adds sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer stages in one clock domain and is driven by the existing FIFO test interface tasks (write, read, read-write, reset).

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- Derived constant: CW = $clog2(DEPTH)+1, the count width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- rd_en  in  1  read/pop request
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Reset values: data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, count=0, overflow=0, underflow=0, wr_ptr=rd_ptr=0.
- Acceptance rules:
  - wr_acc = wr_en & (~full | rd_en).
  - rd_acc = rd_en & ~empty.
  - When full, a simultaneous read and write are both accepted.
  - When empty, a simultaneous read and write accept only the write; the read is rejected.
- count update: count += wr_acc − rd_acc. All flags are registered and derived from the next count, so they are valid in the same cycle as count.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Error flags:
  - overflow sets on wr_en & ~wr_acc.
  - underflow sets on rd_en & ~rd_acc.
  - Both hold until rst or flush.
- flush:
  - Ranks below rst and above everything else.
  - Next cycle: pointers=0, count=0, empty=1, almost_empty=1, full=almost_full=0, overflow=underflow=0.
  - wr_en and rd_en in the flush cycle are ignored.
  - data_out holds its value in standard mode and follows memory in FWFT mode; it is don't-care while empty.
- Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr]. Otherwise data_out holds.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally and is valid whenever empty=0. rd_acc pops and advances the pointer.

## Timing
- Write to visibility:
  - Standard mode: word written at edge N; rd_en at edge N+1 or later; data_out valid after the following edge.
  - FWFT mode: write at edge N; empty=0 and data_out valid after edge N, with no rd_en needed.
- Read latency: 1 cycle in standard mode, 0 cycles in FWFT mode (data precedes the pop).
- No write-to-read bypass when empty; a read in the same cycle as the first write is rejected.
- An asynchronous rst assertion mid-transfer clears all state immediately. Deassertion must be synchronised externally to clk.

## Structure
- Shared package fifo_pkg holds:
  - function cnt_w(depth) returning $clog2(depth)+1
  - enum fifo_mode_e {STD, FWFT}, usable to drive the FWFT parameter
  - parameter-legality checks as elaboration-time assertions (DEPTH a power of two; thresholds in range)
- One sub-module, fifo_mem:
  - DEPTH×DATA_WIDTH flop array
  - synchronous write port, combinational read port
  - no reset on storage
- Top level holds pointers, count, flags, the mode-dependent output register and flush logic. Expected size is about 200 RTL lines.

## Test plan
All scenarios use DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=2.
- Reset, then write 0x01..0x08 -> count 1..8; almost_empty clears at count=3; almost_full sets at count=6; full=1 at count=8.
- Full FIFO, wr_en 0xAA alone -> overflow=1 and count stays 8. Then 8 reads in standard mode -> data_out returns 0x01..0x08, each one cycle after its rd_en; empty=1; 0xAA never appears.
- Full FIFO, simultaneous wr 0x55 and rd -> count stays 8, full stays 1. Then 8 reads -> 0x02..0x08 followed by 0x55, showing wrap-around.
- Empty FIFO, rd_en alone -> underflow=1, data_out unchanged. Then simultaneous wr 0x33 and rd -> count=1 and only the write is accepted.
- FWFT=1: write 0x7E -> after one edge, empty=0 and data_out=0x7E with no read issued. rd_en -> empty=1 next cycle.
- Flush with count=5 and overflow=1 -> next cycle count=0, empty=1, overflow=0. A wr_en asserted in the flush cycle is dropped. Then assert rst mid-burst -> all outputs return to their reset values immediately.
